ddr_init_ctrl: RTL

Parametrised DDR SDRAM power-up and initialisation sequencer, a successor to the fixed-timing init FSM. It drives the DDR command bus and CKE until init_done. It generalises all JEDEC timing gaps, the refresh count and the mode-register contents. It adds an explicit DLL lock window and a software re-initialisation request. It sits between the core reset synchroniser and the command arbiter, which takes the command bus once init_done=1.

---
 rtl/ddr_init_ctrl.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ddr_init_ctrl.sv
// DDR SDRAM power-up / initialisation sequencer: drives CKE and the command bus
// through PRE, EMR, MR(DLL reset), PRE, REFRESH xN, MR, then releases the bus.
module ddr_init_ctrl #(
    parameter int BA_BITS     = 2,
    parameter int ROW_BITS    = 13,
    parameter int CNT_BITS    = 16,
    parameter int T_PWRUP_CYC = 200,
    parameter int T_RP_CYC    = 3,
    parameter int T_MRD_CYC   = 2,
    parameter int T_RFC_CYC   = 10,
    parameter int N_REFRESH   = 2,
    parameter int T_DLL_CYC   = 200
) (
    input  logic                core_clk,
    input  logic                core_rstn_sync,
    input  logic                init_start,
    input  logic [ROW_BITS-1:0] mode_reg,
    input  logic [ROW_BITS-1:0] ext_mode_reg,
    output logic                init_busy,
    output logic                init_done,
    output logic                ddr_cke,
    output logic                ddr_cs_n,
    output logic                ddr_ras_n,
    output logic                ddr_cas_n,
    output logic                ddr_we_n,
    output logic [BA_BITS-1:0]  ddr_ba,
    output logic [ROW_BITS-1:0] ddr_a
);

    typedef enum logic [3:0] {
        S_PWRUP,
        S_CKE_ON,
        S_PRE0,
        S_EMR,
        S_MR_DLLRST,
        S_PRE1,
        S_REF,
        S_MR_CLR,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_LMR   = 4'b0000;

    localparam logic [CNT_BITS:0]   ONE_W    = (CNT_BITS+1)'(1);
    localparam logic [CNT_BITS:0]   PWRUP_T  = (CNT_BITS+1)'(T_PWRUP_CYC);
    localparam logic [CNT_BITS:0]   RP_T     = (CNT_BITS+1)'(T_RP_CYC);
    localparam logic [CNT_BITS:0]   MRD_T    = (CNT_BITS+1)'(T_MRD_CYC);
    localparam logic [CNT_BITS:0]   RFC_T    = (CNT_BITS+1)'(T_RFC_CYC);
    localparam logic [CNT_BITS:0]   DLL_T    = (CNT_BITS+1)'(T_DLL_CYC);
    localparam logic [CNT_BITS-1:0] NREF_T   = CNT_BITS'(N_REFRESH);
    localparam logic [ROW_BITS-1:0] A10_MASK = ROW_BITS'(1) << 10;
    localparam logic [ROW_BITS-1:0] A8_MASK  = ROW_BITS'(1) << 8;

    state_t              state, nxt_state;
    logic [CNT_BITS-1:0] gap, nxt_gap;
    logic [CNT_BITS-1:0] dll, nxt_dll;
    logic [CNT_BITS-1:0] ref_cnt, nxt_ref;
    logic [CNT_BITS:0]   gap_p1, dll_p1;
    logic [CNT_BITS-1:0] gap_sat, dll_sat;
    logic [ROW_BITS-1:0] mode_q, ext_q;
    logic                latch_pending, do_latch, enter, dll_met;

    logic                nxt_cke, nxt_done, nxt_busy;
    logic [3:0]          nxt_cmd;
    logic [BA_BITS-1:0]  nxt_ba;
    logic [ROW_BITS-1:0] nxt_a;

    // gap counts cycles since the current state's command; dll since the DLL-reset LMR
    assign gap_p1  = {1'b0, gap} + ONE_W;
    assign dll_p1  = {1'b0, dll} + ONE_W;
    assign gap_sat = (&gap) ? gap : gap_p1[CNT_BITS-1:0];
    assign dll_sat = (&dll) ? dll : dll_p1[CNT_BITS-1:0];
    assign dll_met = (dll_p1 >= DLL_T);

    always_comb begin
        nxt_state = state;
        enter     = 1'b0;
        nxt_ref   = ref_cnt;
        do_latch  = latch_pending;
        case (state)
            S_PWRUP: begin
                if ({1'b0, gap} >= PWRUP_T) begin
                    nxt_state = S_CKE_ON;
                    enter     = 1'b1;
                end
            end
            S_CKE_ON: begin
                nxt_state = S_PRE0;
                enter     = 1'b1;
            end
            S_PRE0: begin
                if (gap_p1 >= RP_T) begin
                    nxt_state = S_EMR;
                    enter     = 1'b1;
                end
            end
            S_EMR: begin
                if (gap_p1 >= MRD_T) begin
                    nxt_state = S_MR_DLLRST;
                    enter     = 1'b1;
                end
            end
            S_MR_DLLRST: begin
                if (gap_p1 >= MRD_T) begin
                    nxt_state = S_PRE1;
                    enter     = 1'b1;
                end
            end
            S_PRE1: begin
                if (gap_p1 >= RP_T) begin
                    nxt_state = S_REF;
                    enter     = 1'b1;
                    nxt_ref   = CNT_BITS'(1);
                end
            end
            S_REF: begin
                // ref_cnt holds the number of REFRESH commands already issued
                if (gap_p1 >= RFC_T) begin
                    enter = 1'b1;
                    if (ref_cnt >= NREF_T) begin
                        nxt_state = S_MR_CLR;
                    end else begin
                        nxt_state = S_REF;
                        nxt_ref   = ref_cnt + CNT_BITS'(1);
                    end
                end
            end
            S_MR_CLR: begin
                if (gap_p1 >= MRD_T) begin
                    enter     = 1'b1;
                    nxt_state = dll_met ? S_DONE : S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (dll_met) begin
                    nxt_state = S_DONE;
                    enter     = 1'b1;
                end
            end
            S_DONE: begin
                if (init_start) begin
                    nxt_state = S_PRE0;
                    enter     = 1'b1;
                    do_latch  = 1'b1;
                end
            end
            default: begin
                nxt_state = S_PWRUP;
                enter     = 1'b1;
            end
        endcase

        nxt_gap = enter ? '0 : gap_sat;
        nxt_dll = (enter && nxt_state == S_MR_DLLRST) ? '0 : dll_sat;

        // Pins show the next state's command only in its first cycle, NOPs after
        nxt_cke  = 1'b1;
        nxt_cmd  = CMD_NOP;
        nxt_ba   = '0;
        nxt_a    = '0;
        nxt_done = 1'b0;
        nxt_busy = 1'b1;
        case (nxt_state)
            S_PWRUP: begin
                nxt_cke = 1'b0;
                nxt_cmd = CMD_DESEL;
            end
            S_PRE0, S_PRE1: begin
                if (enter) begin
                    nxt_cmd = CMD_PRE;
                    nxt_a   = A10_MASK;
                end
            end
            S_EMR: begin
                if (enter) begin
                    nxt_cmd = CMD_LMR;
                    nxt_ba  = BA_BITS'(1);
                    nxt_a   = ext_q;
                end
            end
            S_MR_DLLRST: begin
                if (enter) begin
                    nxt_cmd = CMD_LMR;
                    nxt_a   = mode_q | A8_MASK;
                end
            end
            S_REF: begin
                if (enter) begin
                    nxt_cmd = CMD_REF;
                end
            end
            S_MR_CLR: begin
                if (enter) begin
                    nxt_cmd = CMD_LMR;
                    nxt_a   = mode_q & ~A8_MASK;
                end
            end
            S_DONE: begin
                nxt_done = 1'b1;
                nxt_busy = 1'b0;
            end
            default: begin
                nxt_cmd = CMD_NOP;
            end
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (!core_rstn_sync) begin
            state         <= S_PWRUP;
            gap           <= '0;
            dll           <= '0;
            ref_cnt       <= '0;
            latch_pending <= 1'b1;
            mode_q        <= '0;
            ext_q         <= '0;
            ddr_cke       <= 1'b0;
            ddr_cs_n      <= 1'b1;
            ddr_ras_n     <= 1'b1;
            ddr_cas_n     <= 1'b1;
            ddr_we_n      <= 1'b1;
            ddr_ba        <= '0;
            ddr_a         <= '0;
            init_done     <= 1'b0;
            init_busy     <= 1'b1;
        end else begin
            state         <= nxt_state;
            gap           <= nxt_gap;
            dll           <= nxt_dll;
            ref_cnt       <= nxt_ref;
            latch_pending <= 1'b0;
            if (do_latch) begin
                mode_q <= mode_reg;
                ext_q  <= ext_mode_reg;
            end
            ddr_cke   <= nxt_cke;
            ddr_cs_n  <= nxt_cmd[3];
            ddr_ras_n <= nxt_cmd[2];
            ddr_cas_n <= nxt_cmd[1];
            ddr_we_n  <= nxt_cmd[0];
            ddr_ba    <= nxt_ba;
            ddr_a     <= nxt_a;
            init_done <= nxt_done;
            init_busy <= nxt_busy;
        end
    end

endmodule
